ur_monitor: RTL
===============

UR_MONITOR -- requirements
Module: ur_monitor

Interface
REQ-001 Parameter N_LANES, default 4: number of monitored lanes, legal range 1..16.
REQ-002 Parameter CNT_W, default 16: width of the per-lane underuse counter and the timeout input.
REQ-003 Parameter DB_LEN, default 2: debounce length in clk cycles, legal range 1..15.
REQ-004 clk  in  1  single system clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 tick  in  1  time-base strobe; one cycle wide, one per 100 ms.
REQ-007 sensor  in  N_LANES  raw vehicle-present inputs, asynchronous to clk.
REQ-008 lane_en  in  N_LANES  lane enable; 0 = lane excluded from monitoring.
REQ-009 timeout  in  CNT_W  underuse threshold in ticks; 300 gives 30 s.
REQ-010 ur_list  out  N_LANES  per-lane underuse flag, registered.
REQ-011 ur_rise  out  N_LANES  one-cycle pulse when the matching ur_list bit goes 0->1.
REQ-012 ur_any  out  1  OR of ur_list, registered.
REQ-013 ur_count  out  $clog2(N_LANES+1)  number of set ur_list bits, registered.

Function
REQ-014 Each sensor bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-015 Per-lane debounce SHALL change state only after the synchronised value differs from the debounced value for DB_LEN consecutive clk cycles. The debounce run counter SHALL clear on any cycle where the two values match.
REQ-016 The per-lane counter cnt[i] SHALL load reload_val when the debounced sensor = 1 or lane_en[i] = 0. reload_val = timeout - 1, or 0 when timeout = 0.
REQ-017 Otherwise, cnt[i] SHALL decrement by 1 on each cycle with tick = 1 and cnt[i] != 0. It SHALL saturate at 0 and never wrap.
REQ-018 timeout SHALL be sampled only at reload. A change while a lane is counting SHALL take effect at that lane's next reload.
REQ-019 ur_list[i] SHALL be registered as (cnt[i] == 0) & lane_en[i] & ~debounced[i], one cycle after cnt reaches 0.
REQ-020 A reload SHALL clear ur_list[i] on the cycle after the reload.
REQ-021 ur_rise[i] SHALL be high for exactly one cycle, aligned with the cycle ur_list[i] first reads 1.
REQ-022 ur_rise[i] SHALL NOT reassert until ur_list[i] has cleared.
REQ-023 ur_any and ur_count SHALL be computed from the ur_list next-state value, so all three outputs update in the same cycle.
REQ-024 A reload condition and tick in the same cycle: the reload SHALL win.
REQ-025 Lanes SHALL be fully independent; simultaneous events on several lanes SHALL be handled in the same cycle with no arbitration.
REQ-026 Latency from a raw sensor edge to the debounced update SHALL be 2 + DB_LEN cycles when the input is stable.

Reset
REQ-027 While rst = 1 on a clock edge, the block SHALL set: cnt[i] = timeout - 1 (0 if timeout = 0), debounced = 0, synchronisers = 0, debounce run counters = 0.
REQ-028 While rst = 1 on a clock edge, the block SHALL set all outputs to 0: ur_list, ur_rise, ur_any, ur_count.
REQ-029 Reset asserted mid-count SHALL discard all lane history.
REQ-030 No ur_rise SHALL be generated on the first cycle after reset release.

Verification (N_LANES=4, CNT_W=16, DB_LEN=2, timeout=5, tick every cycle unless stated)
REQ-031 Lane 0: sensor held 0 after reset -> ur_list[0] rises on the 5th tick after reset plus 1 cycle; ur_rise[0] is one cycle wide; ur_count = 1.
REQ-032 Lane 1: sensor = 1 glitch for 1 cycle mid-count -> no reload, count continues.
REQ-033 Lane 1: sensor = 1 held for 4 cycles -> reload; ur_list[1] clears, and a full 5 ticks are needed before it sets again.
REQ-034 All 4 lanes idle -> ur_count = 4, ur_any = 1, four ur_rise pulses in the same cycle. Then lane_en = 4'b0101 -> ur_count = 2 next cycle.
REQ-035 timeout changed 5 -> 10 while counting -> current interval still 5 ticks; the next interval is 10. timeout = 0 -> flag sets 1 cycle after reload.
REQ-036 rst pulsed while ur_list = 4'hF -> all outputs 0 on the next edge; counting restarts from timeout - 1 after release.

Source files
------------

// File: rtl/ur_monitor_if.sv
// Signal bundle between the lane-underuse monitor and its host: time base,
// sensor/enable inputs, threshold, and the registered underuse flags.
interface ur_monitor_if #(
    parameter int N_LANES = 4,
    parameter int CNT_W   = 16
);
    localparam int CW = $clog2(N_LANES + 1);

    logic               tick;
    logic [N_LANES-1:0] sensor;
    logic [N_LANES-1:0] lane_en;
    logic [CNT_W-1:0]   timeout;
    logic [N_LANES-1:0] ur_list;
    logic [N_LANES-1:0] ur_rise;
    logic               ur_any;
    logic [CW-1:0]      ur_count;

    modport master (
        output tick, sensor, lane_en, timeout,
        input  ur_list, ur_rise, ur_any, ur_count
    );

    modport slave (
        input  tick, sensor, lane_en, timeout,
        output ur_list, ur_rise, ur_any, ur_count
    );
endinterface

// File: rtl/ur_monitor.sv
// Lane underuse monitor: synchronises and debounces per-lane vehicle sensors,
// counts idle ticks per lane and flags lanes that stay idle for `timeout` ticks.
module ur_monitor #(
    parameter int N_LANES = 4,
    parameter int CNT_W   = 16,
    parameter int DB_LEN  = 2
) (
    input logic         clk,
    input logic         rst,
    ur_monitor_if.slave bus
);
    localparam int CW = $clog2(N_LANES + 1);
    localparam int RW = 4;

    logic [N_LANES-1:0] sync1_q, sync1_d;
    logic [N_LANES-1:0] sync2_q, sync2_d;
    logic [N_LANES-1:0] deb_q, deb_d;
    logic [RW-1:0]      run_q [N_LANES];
    logic [RW-1:0]      run_d [N_LANES];
    logic [CNT_W-1:0]   cnt_q [N_LANES];
    logic [CNT_W-1:0]   cnt_d [N_LANES];
    logic               armed_q, armed_d;
    logic [N_LANES-1:0] list_q, list_d;
    logic [N_LANES-1:0] rise_q, rise_d;
    logic               any_q, any_d;
    logic [CW-1:0]      count_q, count_d;

    logic [CNT_W-1:0]   reload_val;
    logic [N_LANES-1:0] reload;

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
        reload_val = (bus.timeout == '0) ? '0 : bus.timeout - CNT_W'(1);
        sync1_d    = bus.sensor;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        reload     = '0;
        list_d     = '0;
        count_d    = '0;
        // armed_q masks flags on the first edge after reset so no rise appears there.
        armed_d    = 1'b1;

        for (int i = 0; i < N_LANES; i++) begin
            run_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (run_q[i] == RW'(DB_LEN - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    run_d[i] = run_q[i] + RW'(1);
                end
            end

            // Reload has priority over tick; timeout is only sampled here.
            reload[i] = deb_q[i] | ~bus.lane_en[i];
            cnt_d[i]  = cnt_q[i];
            if (reload[i]) begin
                cnt_d[i] = reload_val;
            end else if (bus.tick && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end

            list_d[i] = armed_q & (cnt_q[i] == '0) & bus.lane_en[i] & ~deb_q[i];
            count_d   = count_d + CW'(list_d[i]);
        end

        rise_d = list_d & ~list_q;
        any_d  = |list_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            armed_q <= 1'b0;
            list_q  <= '0;
            rise_q  <= '0;
            any_q   <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                run_q[i] <= '0;
                cnt_q[i] <= reload_val;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            armed_q <= armed_d;
            list_q  <= list_d;
            rise_q  <= rise_d;
            any_q   <= any_d;
            count_q <= count_d;
            for (int i = 0; i < N_LANES; i++) begin
                run_q[i] <= run_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.ur_list  = list_q;
    assign bus.ur_rise  = rise_q;
    assign bus.ur_any   = any_q;
    assign bus.ur_count = count_q;
endmodule
